// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide data_memory: sub-word loads/stores, sign/zero extension, RMW for sub-word stores.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_W_en,
  output logic              mem_R_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state;
  logic        we_q, uns_q, rd_cnt;
  logic [1:0]  size_q, lane_q;
  logic [15:0] wdata_q;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data, st_merge;
  logic        trap, rd_last;

  assign req_ready = (state == IDLE);
  assign rd_last   = (rd_cnt == RD_LAT[0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = ((req_size == 2'b01) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Lane selection relies on latched low address bits; word accesses ignore them.
  always_comb begin
    ld_b     = mem_dout[{lane_q, 3'b000} +: 8];
    ld_h     = mem_dout[{lane_q[1], 4'b0000} +: 16];
    st_merge = mem_dout;
    case (size_q)
      2'b00:   ld_data = {{24{ld_b[7] & ~uns_q}}, ld_b};
      2'b01:   ld_data = {{16{ld_h[15] & ~uns_q}}, ld_h};
      default: ld_data = mem_dout;
    endcase
    if (size_q == 2'b00) st_merge[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 st_merge[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      rd_cnt    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_W_en  <= 1'b0;
      mem_R_en  <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          lane_q  <= req_addr[1:0];
          wdata_q <= req_wdata[15:0];
          rd_cnt  <= 1'b0;
          if (trap) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (req_we && req_size[1]) begin
            state    <= WR;
            mem_W_en <= 1'b1;
            mem_din  <= req_wdata;
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          end else begin
            state    <= RD;
            mem_R_en <= 1'b1;
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          end
        end
        RD: if (rd_last) begin
          mem_R_en <= 1'b0;
          if (we_q) begin
            state    <= WR;
            mem_W_en <= 1'b1;
            mem_din  <= st_merge;
          end else begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
          end
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
        WR: begin
          mem_W_en  <= 1'b0;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RSP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load/store vectors with a queue scoreboard, plus a reset-during-RMW sequence.
module tb_mem_access_unit;
  localparam int RD_LAT = 1;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_W_en, mem_R_en;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic        preload;
  logic [31:0] mem [0:15];

  mem_access_unit #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_W_en(mem_W_en),
    .mem_R_en(mem_R_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // data_memory model with one cycle of read latency
  always @(posedge clk) begin
    if (preload) begin
      mem[4] <= 32'h804020F0;
      mem[8] <= 32'h0;
    end else if (mem_W_en) mem[mem_addr[5:2]] <= mem_din;
    if (mem_R_en) mem_dout <= mem[mem_addr[5:2]];
  end

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr, wdata;
    logic [31:0] rdata; logic err; logic [31:0] din;
  } vec_t;
  typedef struct {
    logic [31:0] rdata, din; logic err; int lat, rc, wc; logic both;
  } exp_t;

  int checks = 0, failures = 0;
  exp_t exp_q[$], obs_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input logic [31:0] din);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.din = din;
    return v;
  endfunction

  task automatic do_req(input vec_t v);
    exp_t e, o;
    bit   trapped, done;
    trapped = TRAP && (((v.size == 2'b01) && v.addr[0]) || (v.size[1] && (v.addr[1:0] != 2'b00)));
    e.rdata = v.rdata; e.err = v.err; e.din = v.din; e.both = 1'b0;
    if (trapped)                begin e.lat = 1;          e.rc = 0;          e.wc = 0; end
    else if (!v.we)             begin e.lat = RD_LAT + 2; e.rc = RD_LAT + 1; e.wc = 0; end
    else if (v.size[1])         begin e.lat = 2;          e.rc = 0;          e.wc = 1; end
    else                        begin e.lat = RD_LAT + 3; e.rc = RD_LAT + 1; e.wc = 1; end
    exp_q.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    // scramble inputs after accept; the DUT must ignore them
    req_valid = 1'b0; req_we = ~v.we; req_size = ~v.size; req_unsigned = ~v.uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
    o.rdata = 'x; o.err = 1'bx; o.din = 32'h0; o.lat = 0; o.rc = 0; o.wc = 0; o.both = 1'b0;
    done = 0;
    for (int n = 1; n <= 20 && !done; n++) begin
      if (n > 1) @(negedge clk);
      o.rc += int'(mem_R_en);
      o.wc += int'(mem_W_en);
      if (mem_W_en) o.din = mem_din;
      if (mem_R_en && mem_W_en) o.both = 1'b1;
      if (rsp_valid) begin
        o.lat = n; o.rdata = rsp_rdata; o.err = rsp_err; done = 1;
      end
    end
    obs_q.push_back(o);
  endtask

  initial begin
    exp_t e, o;
    int wseen, vseen;
    rst = 1'b1; preload = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'b0, req_ready}, 32'd1);
    chk("rst_rspv",   {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata",  rsp_rdata, 32'd0);
    chk("rst_err",    {31'b0, rsp_err}, 32'd0);
    chk("rst_wen",    {31'b0, mem_W_en}, 32'd0);
    chk("rst_ren",    {31'b0, mem_R_en}, 32'd0);
    chk("rst_addr",   mem_addr, 32'd0);
    chk("rst_din",    mem_din, 32'd0);
    rst = 1'b0; preload = 1'b0;

    vecs.push_back(mk(0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFF0, 0, 0));  // LB
    vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 0));  // LBU
    vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8040, 0, 0));  // LH
    vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 32'h00008040, 0, 0));  // LHU
    vecs.push_back(mk(0, 2'b00, 0, 32'h12, 32'h0, 32'h00000040, 0, 0));  // LB positive
    vecs.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0, 32'h000020F0, 0, 0));  // LH positive
    vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'h000000AB, 0, 0, 32'h8040ABF0)); // SB
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h8040ABF0, 0, 0));  // LW
    vecs.push_back(mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF)); // SW
    vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0, 0));  // LW
    vecs.push_back(mk(1, 2'b01, 0, 32'h22, 32'hFFFF1234, 0, 0, 32'h1234BEEF)); // SH upper
    vecs.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0, 32'h1234BEEF, 0, 0));  // size 11 as word
    vecs.push_back(mk(0, 2'b00, 1, 32'h21, 32'h0, 32'h000000BE, 0, 0));  // LBU
    vecs.push_back(mk(0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFFBE, 0, 0));  // LB
    vecs.push_back(mk(0, 2'b10, 0, 32'h12, 32'h0, TRAP ? 32'h0 : 32'h8040ABF0, TRAP, 0)); // LW misaligned
    vecs.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0, TRAP ? 32'h0 : 32'hFFFF8040, TRAP, 0)); // LH misaligned

    foreach (vecs[i]) begin
      do_req(vecs[i]);
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.lat == 0) begin
        checks++; failures++;
        $display("FAIL timeout vec%0d: no rsp_valid within 20 cycles", i);
      end else begin
        chk($sformatf("rdata_v%0d", i), o.rdata, e.rdata);
        chk($sformatf("err_v%0d", i), {31'b0, o.err}, {31'b0, e.err});
        chk($sformatf("lat_v%0d", i), o.lat, e.lat);
        chk($sformatf("ren_cycles_v%0d", i), o.rc, e.rc);
        chk($sformatf("wen_cycles_v%0d", i), o.wc, e.wc);
        chk($sformatf("rw_overlap_v%0d", i), {31'b0, o.both}, 32'd0);
        if (e.wc != 0) chk($sformatf("din_v%0d", i), o.din, e.din);
      end
      @(negedge clk);
      chk($sformatf("idle_quiet_v%0d", i), {30'b0, mem_R_en, mem_W_en}, 32'd0);
    end

    // reset while an SH read-modify-write is in its read phase
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b01; req_unsigned = 0;
    req_addr = 32'h12; req_wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("rmw_ren_before_rst", {31'b0, mem_R_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ren", {31'b0, mem_R_en}, 32'd0);
    chk("rst_async_wen", {31'b0, mem_W_en}, 32'd0);
    wseen = 0; vseen = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      wseen += int'(mem_W_en);
      vseen += int'(rsp_valid);
    end
    chk("rst_no_write", wseen, 0);
    chk("rst_no_rsp", vseen, 0);
    chk("rst_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_unchanged", mem[4], 32'h8040ABF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
